decoded_bit_packer: RTL

//  Downstream of the symbol-decision stage. Buffers its 12-bit decoded bit words ({b2[3:0], b1[7:0]}).

---
 rtl/decoded_bit_packer_pkg.sv | 14 +
 rtl/decoded_bit_packer_sync_fifo.sv | 61 ++++++
 rtl/decoded_bit_packer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/decoded_bit_packer_pkg.sv
// Shared constants and state type for the decoded-bit packer.
package decoded_bit_packer_pkg;

    localparam int unsigned WORD_W = 12;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NIB_W  = WORD_W - BYTE_W;

    typedef enum logic [1:0] {
        S_W0,
        S_NIB,
        S_BYTE
    } pack_state_t;

endpackage

// File: rtl/decoded_bit_packer_sync_fifo.sv
// Single-clock FIFO; read data is the stored entry at the head pointer.
module decoded_bit_packer_sync_fifo #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              pop_i,
    output logic [WIDTH-1:0]  rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o
);

    localparam logic [ADDR_W:0] FullLevel = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   level_q, level_d;
    logic              do_push, do_pop;

    assign full_o  = (level_q == FullLevel);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        level_d = level_q;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/decoded_bit_packer.sv
// Buffers 12-bit decoded words and repacks them MSB-first into a backpressured byte stream.
module decoded_bit_packer
    import decoded_bit_packer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [WORD_W-1:0] in_word_i,
    input  logic              in_flush_i,
    input  logic              clr_overflow_i,
    output logic [BYTE_W-1:0] out_byte_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic              overflow_o,
    output logic [ADDR_W:0]   fifo_level_o
);

    pack_state_t       state_q;
    logic [NIB_W-1:0]  nib_q;
    logic [BYTE_W-1:0] hold_q;
    logic [BYTE_W-1:0] out_byte_q;
    logic              out_valid_q, out_last_q;
    logic              flush_pending_q, flush_pending_d;
    logic              overflow_q, overflow_d;

    logic              out_free, fifo_pop, fifo_push, fifo_full, fifo_empty, flush_done, drop;
    logic [WORD_W-1:0] head;

    assign out_free   = ~out_valid_q | out_ready_i;
    assign fifo_pop   = out_free & ~fifo_empty & (state_q != S_BYTE);
    assign fifo_push  = in_valid_i & (~fifo_full | fifo_pop);
    assign drop       = in_valid_i & fifo_full & ~fifo_pop;
    // Every state retires a pending flush once the FIFO has run dry at an advance.
    assign flush_done = out_free & fifo_empty & flush_pending_q;

    decoded_bit_packer_sync_fifo #(
        .WIDTH  (WORD_W),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (in_word_i),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_W0;
            nib_q       <= '0;
            hold_q      <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (out_free) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            unique case (state_q)
                S_W0: begin
                    if (!fifo_empty) begin
                        out_byte_q  <= head[WORD_W-1 -: BYTE_W];
                        nib_q       <= head[NIB_W-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= S_NIB;
                    end
                end
                S_NIB: begin
                    if (!fifo_empty) begin
                        out_byte_q  <= {nib_q, head[WORD_W-1 -: NIB_W]};
                        hold_q      <= head[BYTE_W-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= S_BYTE;
                    end else if (flush_pending_q) begin
                        out_byte_q  <= {nib_q, {NIB_W{1'b0}}};
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b1;
                        state_q     <= S_W0;
                    end
                end
                S_BYTE: begin
                    out_byte_q  <= hold_q;
                    out_valid_q <= 1'b1;
                    out_last_q  <= flush_done;
                    state_q     <= S_W0;
                end
                default: state_q <= S_W0;
            endcase
        end
    end

    always_comb begin
        flush_pending_d = (flush_pending_q & ~flush_done) | in_flush_i;
        overflow_d      = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pending_q <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            flush_pending_q <= flush_pending_d;
            overflow_q      <= overflow_d;
        end
    end

    assign out_byte_o  = out_byte_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign overflow_o  = overflow_q;

endmodule
